// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and FSM encoding for the UART transmit buffer.
package uart_tx_fifo_pkg;

  // Width of one UART character.
  localparam int UART_DW = 8;

  // Default buffer depth and the matching pointer width.
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;

  // Drain FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Generic synchronous circular FIFO with a separate occupancy counter.
// It is shared by the transmit and receive buffers.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;

  logic push_ok;
  logic pop_ok;

  // The full/empty checks use the pre-edge count, so a push into a full
  // FIFO is dropped even when a pop happens on the same edge.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

  // Head-of-queue byte; the consumer registers it when it pops.
  assign rd_data = mem[rd_ptr_reg];

  // Storage write; the array carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Next pointer and count values; flush has priority over everything.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      count_next = count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte buffer: queues bus writes and feeds the UART
// transmitter one byte per tx_start/tx_ready handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               flush,
  input  logic               clr_ovf,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count,
  output logic               overflow,
  input  logic               tx_ready,
  output logic               tx_start,
  output logic [UART_DW-1:0] tx_data
);

  tx_state_t          state_reg, state_next;
  logic               tx_start_reg, tx_start_next;
  logic [UART_DW-1:0] tx_data_reg, tx_data_next;
  logic               overflow_reg, overflow_next;

  logic               pop_go;
  logic               ovf_event;
  logic [UART_DW-1:0] head_data;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (UART_DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop_go),
    .flush     (flush),
    .rd_data   (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // A byte leaves the FIFO only on the IDLE->BUSY transition.
  assign pop_go    = (state_reg == S_IDLE) && !empty && tx_ready && !flush;

  // A flush swallows a same-cycle push without counting it as lost.
  assign ovf_event = wr_en && full && !flush;

  // Sticky overflow: a new drop wins over a simultaneous clear.
  always_comb begin
    overflow_next = overflow_reg;
    if (ovf_event) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // Drain FSM next-state and output logic. BUSY waits for tx_ready to fall
  // and WAIT for it to rise, so each byte gets exactly one start pulse.
  always_comb begin
    state_next    = state_reg;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (pop_go) begin
          tx_data_next  = head_data;
          tx_start_next = 1'b1;
          state_next    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!tx_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM, output and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
      overflow_reg <= overflow_next;
    end
  end

  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign overflow = overflow_reg;

endmodule
